// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types: FSM state encoding, instruction constants and
// the fetch/decode register bundle layout {instr[31:16], pc2[15:0]}.
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        ST_REQ  = 3'd0,
        ST_WAIT = 3'd1,
        ST_HOLD = 3'd2,
        ST_DROP = 3'd3,
        ST_HALT = 3'd4
    } fetch_state_e;

    localparam logic [15:0] RESET_PC_DEF  = 16'h0000;
    localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;
    localparam logic [4:0]  HALT_OPC_DEF  = 5'b00000;
    localparam logic [15:0] PC_STEP       = 16'd2;

    // Must stay bit-compatible with the 32-bit fetch/decode register.
    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc2;
    } fd_bundle_t;

    function automatic logic [4:0] opcode(input logic [15:0] instr);
        return instr[15:11];
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: request/done handshake plus error flag.
interface fetch_unit_if;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_done;
    logic        imem_err;

    modport master (output imem_rd, imem_addr, input imem_data, imem_done, imem_err);
    modport slave  (input imem_rd, imem_addr, output imem_data, imem_done, imem_err);
endinterface

// File: rtl/fetch_unit_buf.sv
// Fetch output buffer {valid, instr, pc2}. Kill masks the current output and
// clears the entry; an entry neither loaded nor held turns into a bubble.
module fetch_buf
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        hold_i,
    input  logic        kill_i,
    input  fd_bundle_t  data_i,
    output logic        valid_o,
    output logic [15:0] instr_o,
    output logic [15:0] pc2_o
);
    logic       valid_q, valid_d;
    fd_bundle_t bndl_q, bndl_d;

    always_comb begin
        valid_d = valid_q;
        bndl_d  = bndl_q;
        if (kill_i || !(load_i || hold_i)) begin
            valid_d      = 1'b0;
            bndl_d.instr = NOP_INSTR;
        end else if (load_i) begin
            valid_d = 1'b1;
            bndl_d  = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            bndl_q  <= '{instr: NOP_INSTR, pc2: 16'h0000};
        end else begin
            valid_q <= valid_d;
            bndl_q  <= bndl_d;
        end
    end

    assign valid_o = valid_q & ~kill_i;
    assign instr_o = kill_i ? NOP_INSTR : bndl_q.instr;
    assign pc2_o   = bndl_q.pc2;
endmodule

// File: rtl/rca_16b.sv
// 16-bit ripple-carry adder; carry-out is not needed by its users.
module rca_16b (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o
);
    logic carry;

    always_comb begin
        carry = cin_i;
        sum_o = '0;
        for (int i = 0; i < 16; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, multi-cycle imem handshake, stall,
// redirect and HALT handling, sticky fetch error.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter logic [4:0]  HALT_OPC  = HALT_OPC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    fetch_unit_if.master        imem,
    input  logic                fd_stall_i,
    input  logic                redir_valid_i,
    input  logic [15:0]         redir_pc_i,
    output logic                fd_valid_o,
    output logic [15:0]         fd_instr_o,
    output logic [15:0]         fd_pc2_o,
    output logic                halted_o,
    output logic                err_o
);
    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  pend_q, pend_d;
    logic [15:0]  pc_inc;
    logic         err_q, err_d;
    logic         ign_q;
    logic         buf_load, buf_hold, buf_kill;
    fd_bundle_t   buf_in;

    rca_16b u_pc_inc (
        .a_i   (pc_q),
        .b_i   (PC_STEP),
        .cin_i (1'b0),
        .sum_o (pc_inc)
    );

    assign buf_in = '{instr: imem.imem_data, pc2: pc_inc};

    fetch_buf #(.NOP_INSTR(NOP_INSTR)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (buf_load),
        .hold_i  (buf_hold),
        .kill_i  (buf_kill),
        .data_i  (buf_in),
        .valid_o (fd_valid_o),
        .instr_o (fd_instr_o),
        .pc2_o   (fd_pc2_o)
    );

    // A redirect in REQ suppresses the read so no orphan done can come back.
    assign imem.imem_rd   = (state_q == ST_REQ) && !redir_valid_i;
    assign imem.imem_addr = pc_q;
    assign halted_o       = (state_q == ST_HALT);
    assign err_o          = err_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pend_d   = pend_q;
        buf_load = 1'b0;
        buf_hold = 1'b0;
        buf_kill = 1'b0;
        unique case (state_q)
            ST_REQ: begin
                if (redir_valid_i) begin
                    buf_kill = 1'b1;
                    pc_d     = redir_pc_i;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redir_valid_i) begin
                    if (imem.imem_done) begin
                        pc_d    = redir_pc_i;
                        state_d = ST_REQ;
                    end else begin
                        pend_d  = redir_pc_i;
                        state_d = ST_DROP;
                    end
                end else if (imem.imem_done) begin
                    buf_load = 1'b1;
                    if (opcode(imem.imem_data) == HALT_OPC) begin
                        state_d = ST_HALT;
                    end else if (fd_stall_i) begin
                        state_d = ST_HOLD;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_HOLD: begin
                if (redir_valid_i) begin
                    buf_kill = 1'b1;
                    pc_d     = redir_pc_i;
                    state_d  = ST_REQ;
                end else if (fd_stall_i) begin
                    buf_hold = 1'b1;
                end else begin
                    pc_d    = pc_inc;
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                if (redir_valid_i) begin
                    if (imem.imem_done) begin
                        pc_d    = redir_pc_i;
                        state_d = ST_REQ;
                    end else begin
                        pend_d = redir_pc_i;
                    end
                end else if (imem.imem_done) begin
                    pc_d    = pend_q;
                    state_d = ST_REQ;
                end
            end
            ST_HALT: begin
                if (redir_valid_i) begin
                    buf_kill = 1'b1;
                    pc_d     = redir_pc_i;
                    state_d  = ST_REQ;
                end else begin
                    buf_hold = fd_stall_i;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    // ign_q masks a done left over from a read that reset abandoned.
    always_comb begin
        err_d = err_q | imem.imem_err | (imem.imem_rd & pc_q[0]);
        if (imem.imem_done && !ign_q && (state_q == ST_REQ || state_q == ST_HALT))
            err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            err_q   <= 1'b0;
            ign_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            ign_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        pend_q <= pend_d;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed cycle-by-cycle vectors for fetch_unit with hand-computed outputs.
module tb_fetch_unit;
    localparam logic [15:0] NOP = 16'h0800;
    localparam logic [15:0] Z   = 16'h0000;

    typedef struct {
        logic        r;     logic chk;
        logic        done;  logic [15:0] data;
        logic        stall; logic redir; logic [15:0] rpc; logic ierr;
        logic        rd;    logic [15:0] addr;
        logic        fv;    logic [15:0] fi; logic [15:0] fp;
        logic        hlt;   logic er;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fd_stall, redir_valid;
    logic [15:0] redir_pc;
    logic        fd_valid, halted, err;
    logic [15:0] fd_instr, fd_pc2;
    int          tests = 0;
    int          fails = 0;
    vec_t        tbl[$];

    fetch_unit_if bus();

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (bus),
        .fd_stall_i    (fd_stall),
        .redir_valid_i (redir_valid),
        .redir_pc_i    (redir_pc),
        .fd_valid_o    (fd_valid),
        .fd_instr_o    (fd_instr),
        .fd_pc2_o      (fd_pc2),
        .halted_o      (halted),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    function automatic vec_t V(input logic r, c, dn, input logic [15:0] d, input logic st, rv,
                               input logic [15:0] rp, input logic ie, input logic erd,
                               input logic [15:0] ea, input logic efv, input logic [15:0] efi, efp,
                               input logic eh, ee);
        vec_t t;
        t.r = r; t.chk = c; t.done = dn; t.data = d; t.stall = st; t.redir = rv; t.rpc = rp;
        t.ierr = ie; t.rd = erd; t.addr = ea; t.fv = efv; t.fi = efi; t.fp = efp; t.hlt = eh; t.er = ee;
        return t;
    endfunction

    function automatic vec_t RST();
        return V(1, 0, 0, Z, 0, 0, Z, 0, 0, Z, 0, NOP, Z, 0, 0);
    endfunction

    task automatic step(input vec_t t, input string name);
        logic ok;
        @(negedge clk);
        rst = t.r; bus.imem_done = t.done; bus.imem_data = t.data; bus.imem_err = t.ierr;
        fd_stall = t.stall; redir_valid = t.redir; redir_pc = t.rpc;
        #1;
        if (t.chk) begin
            tests++;
            ok = (bus.imem_rd === t.rd) && (!t.rd || bus.imem_addr === t.addr) &&
                 (fd_valid === t.fv) && (fd_instr === t.fi) && (!t.fv || fd_pc2 === t.fp) &&
                 (halted === t.hlt) && (err === t.er);
            if (!ok) begin
                fails++;
                $display("FAIL %s: got rd=%0b addr=%h fv=%0b instr=%h pc2=%h halted=%0b err=%0b, want rd=%0b addr=%h fv=%0b instr=%h pc2=%h halted=%0b err=%0b",
                         name, bus.imem_rd, bus.imem_addr, fd_valid, fd_instr, fd_pc2, halted, err,
                         t.rd, t.addr, t.fv, t.fi, t.fp, t.hlt, t.er);
            end
        end
    endtask

    initial begin
        rst = 1'b1; fd_stall = 1'b0; redir_valid = 1'b0; redir_pc = Z;
        bus.imem_done = 1'b0; bus.imem_data = Z; bus.imem_err = 1'b0;

        // Straight-line fetch with 1-cycle memory
        tbl.push_back(RST());
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          1,16'h0000, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 1,16'h4000,0,0,Z,0,   0,Z, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          1,16'h0002, 1,16'h4000,16'h0002, 0,0));
        tbl.push_back(V(0,1, 1,16'h4101,0,0,Z,0,   0,Z, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          1,16'h0004, 1,16'h4101,16'h0004, 0,0));
        tbl.push_back(V(0,1, 1,16'h4202,0,0,Z,0,   0,Z, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          1,16'h0006, 1,16'h4202,16'h0006, 0,0));
        // Stall for 3 cycles on the first instruction
        tbl.push_back(RST());
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          1,16'h0000, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 1,16'h4000,1,0,Z,0,   0,Z, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 0,Z,1,0,Z,0,          0,Z, 1,16'h4000,16'h0002, 0,0));
        tbl.push_back(V(0,1, 0,Z,1,0,Z,0,          0,Z, 1,16'h4000,16'h0002, 0,0));
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          0,Z, 1,16'h4000,16'h0002, 0,0));
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          1,16'h0002, 0,NOP,Z, 0,0));
        // Redirect while a 5-cycle read of 0006 is pending -> DROP
        tbl.push_back(V(0,1, 1,16'h4101,0,0,Z,0,   0,Z, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          1,16'h0004, 1,16'h4101,16'h0004, 0,0));
        tbl.push_back(V(0,1, 1,16'h4202,0,0,Z,0,   0,Z, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          1,16'h0006, 1,16'h4202,16'h0006, 0,0));
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          0,Z, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 0,Z,0,1,16'h0040,0,   0,Z, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          0,Z, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          0,Z, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 1,16'h4303,0,0,Z,0,   0,Z, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          1,16'h0040, 0,NOP,Z, 0,0));
        // done and redirect together in WAIT
        tbl.push_back(V(0,1, 1,16'h4404,0,1,16'h0100,0, 0,Z, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          1,16'h0100, 0,NOP,Z, 0,0));
        // Redirect in REQ kills the presented instruction, then HALT at 0010
        tbl.push_back(V(0,1, 1,16'h4505,0,0,Z,0,   0,Z, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 0,Z,0,1,16'h0010,0,   0,Z, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          1,16'h0010, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 1,16'h0000,0,0,Z,0,   0,Z, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          0,Z, 1,16'h0000,16'h0012, 1,0));
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          0,Z, 0,NOP,Z, 1,0));
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          0,Z, 0,NOP,Z, 1,0));
        tbl.push_back(V(0,1, 0,Z,0,1,16'h0020,0,   0,Z, 0,NOP,Z, 1,0));
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          1,16'h0020, 0,NOP,Z, 0,0));
        // PC wrap at FFFE, HALT, spurious done in HALT sets sticky err
        tbl.push_back(V(0,1, 1,16'h4606,0,0,Z,0,   0,Z, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 0,Z,0,1,16'hFFFE,0,   0,Z, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          1,16'hFFFE, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 1,16'h4707,0,0,Z,0,   0,Z, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          1,16'h0000, 1,16'h4707,16'h0000, 0,0));
        tbl.push_back(V(0,1, 1,16'h0000,0,0,Z,0,   0,Z, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          0,Z, 1,16'h0000,16'h0002, 1,0));
        tbl.push_back(V(0,1, 1,Z,0,0,Z,0,          0,Z, 0,NOP,Z, 1,0));
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          0,Z, 0,NOP,Z, 1,1));
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          0,Z, 0,NOP,Z, 1,1));
        // Reset clears err; odd PC at request sets it
        tbl.push_back(RST());
        tbl.push_back(V(0,1, 0,Z,0,1,16'h0031,0,   0,Z, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          1,16'h0031, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          0,Z, 0,NOP,Z, 0,1));
        // imem_err sets err
        tbl.push_back(RST());
        tbl.push_back(V(0,1, 0,Z,0,0,Z,1,          1,16'h0000, 0,NOP,Z, 0,0));
        tbl.push_back(V(0,1, 0,Z,0,0,Z,0,          0,Z, 0,NOP,Z, 0,1));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

        // Reset mid-request: a stale done in the first cycle is ignored
        step(RST(), "mid_rst0");
        step(V(0,1, 0,Z,0,0,Z,0,          1,16'h0000, 0,NOP,Z, 0,0), "mid_req");
        step(V(0,1, 0,Z,0,0,Z,0,          0,Z, 0,NOP,Z, 0,0), "mid_wait");
        step(RST(), "mid_rst1");
        step(V(0,1, 1,16'h4ABC,0,0,Z,0,   1,16'h0000, 0,NOP,Z, 0,0), "stale_done");
        step(V(0,1, 1,16'h4000,0,0,Z,0,   0,Z, 0,NOP,Z, 0,0), "post_rst_wait");
        step(V(0,1, 0,Z,0,0,Z,0,          1,16'h0002, 1,16'h4000,16'h0002, 0,0), "post_rst_out");

        // Second redirect in DROP overwrites the pending PC
        step(RST(), "drop_rst");
        step(V(0,1, 0,Z,0,0,Z,0,          1,16'h0000, 0,NOP,Z, 0,0), "drop_req");
        step(V(0,1, 0,Z,0,1,16'h0200,0,   0,Z, 0,NOP,Z, 0,0), "drop_enter");
        step(V(0,1, 0,Z,0,1,16'h0300,0,   0,Z, 0,NOP,Z, 0,0), "drop_overwrite");
        step(V(0,1, 1,16'h4111,0,0,Z,0,   0,Z, 0,NOP,Z, 0,0), "drop_discard");
        step(V(0,1, 0,Z,0,0,Z,0,          1,16'h0300, 0,NOP,Z, 0,0), "drop_target");
        // Spurious done in REQ (not right after reset) sets err
        step(V(0,1, 1,16'h4222,0,0,Z,0,   0,Z, 0,NOP,Z, 0,0), "req_wait");
        step(V(0,1, 1,Z,0,0,Z,0,          1,16'h0302, 1,16'h4222,16'h0302, 0,0), "req_spurious");
        step(V(0,1, 0,Z,0,0,Z,0,          0,Z, 0,NOP,Z, 0,1), "req_err");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the 5-stage pipelined processor. Owns the PC register. Issues reads to a multi-cycle instruction memory with a request/done handshake. Delivers {instruction, PC+2} plus a valid bit to the fetch/decode pipeline register, and handles stalls, branch/jump redirects and HALT.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0800, instruction driven to decode when no valid instruction is present
HALT_OPC, 5'b00000, opcode in bits [15:11] that stops fetch

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
imem_rd  out  1  one-cycle read request pulse
imem_addr  out  16  read address; equals PC while a request is outstanding
imem_data  in  16  read data; valid only when imem_done=1
imem_done  in  1  read complete pulse, earliest 1 cycle after imem_rd
imem_err  in  1  memory error flag (unaligned address or parity)
fd_stall  in  1  hazard unit holds the fetch/decode register
redir_valid  in  1  execute stage has a taken branch/jump
redir_pc  in  16  redirect target
fd_valid  out  1  fd_instr/fd_pc2 carry a real instruction
fd_instr  out  16  instruction to decode
fd_pc2  out  16  PC of fd_instr + 2
halted  out  1  fetch has stopped on HALT
err  out  1  sticky error; ORed into the processor err

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: PC=RESET_PC, state=REQ, imem_rd=0, fd_valid=0, fd_instr=NOP_INSTR, fd_pc2=0, halted=0, err=0. A reset mid-request drops the outstanding read; any imem_done in the first cycle after reset is ignored and does not set err.
- State REQ: drive imem_rd=1 and imem_addr=PC for one cycle, then go to WAIT.
- State WAIT: imem_rd=0.
  - On imem_done: latch imem_data into the output buffer, set fd_pc2=PC+2 (16-bit, wraps FFFE->0000) and fd_valid=1.
  - After the latch, if the opcode equals HALT_OPC, go to HALT. Otherwise go to HOLD if fd_stall=1, else set PC=PC+2 and go to REQ.
- State HOLD: outputs stay frozen while fd_stall=1. When fd_stall=0 the instruction is consumed that cycle: PC=PC+2, go to REQ.
- Output timing: fd_valid is 1 only in the cycle the buffer is presented and decode accepts it. In a REQ or WAIT cycle with no new data, fd_valid=0 and fd_instr=NOP_INSTR, so a bubble is inserted.
- Throughput: with 1-cycle memory, 2 cycles per instruction (REQ, WAIT).
- Redirect has priority over stall and halt:
  - In REQ, HOLD or HALT: the buffer is killed (fd_valid=0, NOP), PC=redir_pc, halted=0, go to REQ.
  - In WAIT with a read pending: go to DROP and record redir_pc as the pending PC.
- State DROP: wait for imem_done and discard its data (fd_valid stays 0). Then PC=pending PC, go to REQ. A further redirect in DROP overwrites the pending PC.
- Simultaneous imem_done and redir_valid in WAIT: the data is discarded and redir_pc is applied directly (go to REQ). DROP is not entered.
- State HALT: halted=1, imem_rd=0. The HALT instruction is still presented once, with fd_valid=1 and honouring fd_stall, so it reaches memory stage dump logic. After that fd_valid=0. Only a redirect or reset leaves HALT.
- err sets and stays set (until rst) on any of:
  - imem_done while in REQ or HALT (no outstanding request);
  - imem_err=1 in any cycle;
  - PC[0]=1 when a request is issued.
- Widths: all PC arithmetic is 16-bit unsigned modulo 2^16.

Decomposition:
- Shared package/include: state encodings (REQ, WAIT, HOLD, DROP, HALT as 3-bit localparams), NOP_INSTR and HALT_OPC constants, and the fetch/decode bundle layout {instr[31:16], pc2[15:0]}. This layout must match the 32-bit fetch/decode register.
- The PC+2 incrementor reuses the existing rca_16b.
- One natural sub-module, fetch_buf: the 33-bit output buffer {valid, instr, pc2} with load, hold and kill controls.
- The FSM, PC register and error logic stay in fetch_unit.

Test Plan:
1. Reset with 1-cycle memory returning 16'h4000,16'h4101,16'h4202 -> imem_addr 0000,0002,0004. fd_valid pulses every 2nd cycle with fd_pc2 = 0002,0004,0006.
2. Memory returns 16'h4000 at PC 0000; fd_stall=1 for 3 cycles -> fd_instr holds 4000 and fd_pc2 holds 0002 for 3 cycles, and no imem_rd is issued. The next request goes to 0002 the cycle after fd_stall drops.
3. redir_valid with redir_pc=0040 while WAIT is pending on 0006 (5-cycle memory) -> data for 0006 is discarded with fd_valid=0. The next imem_rd addresses 0040.
4. imem_done and redir_valid (redir_pc=0100) in the same cycle -> no fd_valid for that data. The next imem_addr is 0100 and DROP is not entered.
5. Fetch 16'h0000 at PC 0010 -> presented once with fd_valid=1 and fd_pc2=0012, then halted=1 with no further imem_rd. A later redirect to 0020 clears halted and fetches 0020.
6. PC at FFFE -> fd_pc2=0000 (wrap). A spurious imem_done in HALT sets err=1, and err stays 1 until rst.
